// File: rtl/norm_ctrl_pkg.sv
// rtl/norm_ctrl_pkg.sv - shared constants, FSM state codes and helpers for the normaliser arbiter
package norm_ctrl_pkg;

    // Default row geometry, shared with the normaliser and its wrappers
    localparam int NORM_BW_PSUM = 20;
    localparam int NORM_COL     = 8;

    typedef logic [2:0] norm_state_t;

    localparam norm_state_t ST_IDLE  = 3'd0;
    localparam norm_state_t ST_ISSUE = 3'd1;
    localparam norm_state_t ST_BUSY  = 3'd2;
    localparam norm_state_t ST_DONE  = 3'd3;
    localparam norm_state_t ST_SETTL = 3'd4;
    localparam norm_state_t ST_RESP  = 3'd5;

    // Index width for n items, never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/norm_arbiter_rr_arbiter.sv
// rtl/norm_arbiter_rr_arbiter.sv - round-robin grant search that owns the rotating priority pointer
module rr_arbiter
    import norm_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             update,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW:0]   cand;
    logic           found;

    // First active request at or after the pointer, wrapping modulo N_REQ (not necessarily a power of 2)
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[IDW-1:0]]  = 1'b1;
                grant_idx             = cand[IDW-1:0];
            end
        end
    end

    // After a grant, the requester just served drops to lowest priority
    always_comb begin
        ptr_d = ptr_q;
        if (update) begin
            ptr_d = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/norm_arbiter.sv
// rtl/norm_arbiter.sv - shares one row normaliser between requesters; optional watchdog under NORM_ARB_TIMEOUT_EN
module norm_arbiter
    import norm_ctrl_pkg::*;
#(
    parameter int BW_PSUM = NORM_BW_PSUM,
    parameter int COL     = NORM_COL,
    parameter int N_REQ   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64,
    localparam int ROW_W  = BW_PSUM*COL,
    localparam int IDW    = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ROW_W-1:0] req_data,
    output logic [ROW_W-1:0]       norm_in,
    output logic                   norm_valid,
    input  logic                   norm_done,
    input  logic [ROW_W-1:0]       norm_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ROW_W-1:0]       resp_data,
    output logic [IDW-1:0]         resp_id,
    output logic                   resp_err
);

    localparam int SCW = id_width(SETTLE);

    norm_state_t      state_q, state_d;
    logic [ROW_W-1:0] norm_in_q, norm_in_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic             resp_valid_q, resp_valid_d;
    logic [ROW_W-1:0] resp_data_q, resp_data_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             arb_update;

`ifdef NORM_ARB_TIMEOUT_EN
    localparam int WDW = id_width(TIMEOUT);
    logic [WDW-1:0]   wd_q, wd_d;
    logic             err_q, err_d;
`else
    // The watchdog limit has no effect when the watchdog is compiled out
    localparam int unused_timeout = TIMEOUT;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .update    (arb_update),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready  = (state_q == ST_IDLE) ? grant : '0;
    assign norm_valid = (state_q == ST_ISSUE);
    assign norm_in    = norm_in_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
`ifdef NORM_ARB_TIMEOUT_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

    // Job sequencing: grant, start pulse, div_complete handshake, settle, response
    always_comb begin
        state_d      = state_q;
        norm_in_d    = norm_in_q;
        id_d         = id_q;
        settle_d     = settle_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        arb_update   = 1'b0;
`ifdef NORM_ARB_TIMEOUT_EN
        wd_d         = wd_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A grant only exists for a valid requester, so a grant is the handshake
                if (|grant) begin
                    norm_in_d  = req_data[grant_idx*ROW_W +: ROW_W];
                    id_d       = grant_idx;
                    arb_update = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
`ifdef NORM_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            ST_BUSY: begin
                if (!norm_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (norm_done) begin
                    settle_d = '0;
                    state_d  = ST_SETTL;
                end
            end
            ST_SETTL: begin
                if (settle_q == SCW'(SETTLE-1)) begin
                    resp_data_d  = norm_out;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
`ifdef NORM_ARB_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                    state_d      = ST_RESP;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef NORM_ARB_TIMEOUT_EN
        // Watchdog overrides the normal BUSY/DONE progress when the normaliser hangs
        if (state_q == ST_BUSY || state_q == ST_DONE) begin
            if (wd_q == WDW'(TIMEOUT-1)) begin
                resp_data_d  = '0;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                err_d        = 1'b1;
                state_d      = ST_RESP;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // State and data registers; reset abandons any job in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            norm_in_q    <= '0;
            id_q         <= '0;
            settle_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
`ifdef NORM_ARB_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            norm_in_q    <= norm_in_d;
            id_q         <= id_d;
            settle_q     <= settle_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
`ifdef NORM_ARB_TIMEOUT_EN
            wd_q         <= wd_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule
